alu_mul_seq: RTL and testbench
==============================

Name: alu_mul_seq

Overview:
Multi-cycle shift-add multiplier sequencer that borrows the execute-stage 16-bit ALU to form a 32-bit product.
- When idle, every ALU input is passed straight through from the execute stage.
- While multiplying, the block owns the ALU, issues ADD operations itself and stalls the pipeline.
- Sits in EX, between the execute-stage operand muxes and the ALU instance.

Parameters:
WIDTH, 16, operand width; must match the ALU datapath.
CNT_W, 4, iteration counter width; must equal log2(WIDTH).

Ports:
clk  in  1  clock.
rst  in  1  synchronous, active-high reset.
start  in  1  level from the EX instruction requesting a multiply.
mul_signed  in  1  signed multiply request (see Optional Feature).
opA  in  WIDTH  multiplicand.
opB  in  WIDTH  multiplier.
ex_A, ex_B  in  WIDTH  pipeline ALU operands.
ex_Op  in  16  pipeline ALU Op (instruction bits).
ex_Cin, ex_invA, ex_invB, ex_sign  in  1 each  pipeline ALU controls.
alu_Out  in  WIDTH  ALU result.
alu_Cout  in  1  ALU carry out.
alu_A, alu_B  out  WIDTH  driven ALU operands.
alu_Op  out  16  driven ALU Op.
alu_Cin, alu_invA, alu_invB, alu_sign  out  1 each  driven ALU controls.
stall  out  1  holds the pipeline (IF/ID/EX) while high.
done  out  1  product valid, one-cycle pulse.
product  out  2*WIDTH  product; held until the next start is accepted.

Behaviour:
- States: IDLE, ITER, DONE. Registers: state, cnt, M (multiplicand), P_hi, P_lo, neg.
- Reset: state=IDLE; cnt, M, P_hi, P_lo, neg = 0. Outputs after reset: done=0, product=0, stall=0.
- IDLE:
  - start=1 loads M=opA, P_hi=0, P_lo=opB, cnt=0, then goes to ITER.
  - stall = start, combinationally, in the same cycle.
- ITER:
  - ALU drive: alu_A=P_hi; alu_B = P_lo[0] ? M : 0; alu_Cin=0; alu_Op=OP_ADD (16'hD800, R-format ADD); alu_invA=alu_invB=alu_sign=0.
  - Clock edge: {P_hi,P_lo} <= {alu_Cout, alu_Out, P_lo[WIDTH-1:1]}; cnt <= cnt+1.
  - cnt wrap from WIDTH-1 moves to DONE.
  - stall=1 throughout.
- DONE:
  - done=1, stall=0, product={P_hi,P_lo}; the EX instruction retires this cycle.
  - Next state is IDLE unconditionally.
- Latency: start sampled in IDLE at cycle 0 gives done at cycle WIDTH+1 (17).
- Passthrough: in IDLE and DONE, every alu_* output equals its ex_* input, combinationally.
- start is ignored in ITER and DONE. In DONE it is still the same instruction's level, so no re-trigger occurs.
- rst mid-operation: IDLE on the next edge and the partial product is discarded; done never pulses.
- opA or opB = 0: still takes the full WIDTH iterations (fixed latency).
- Unsigned path: carry captured from alu_Cout, no overflow possible within 2*WIDTH bits.

Optional Feature:
MUL_SIGNED_EN
- Defined:
  - On load with mul_signed=1, M=|opA| and P_lo=|opB|, using local negation rather than the ALU; neg = opA[MSB] ^ opB[MSB].
  - product is the two's-complement negation of {P_hi,P_lo} when neg=1.
  - -32768 magnitude is treated as unsigned 0x8000.
- Undefined: mul_signed is ignored, neg is always 0, and the negation logic is absent.

Decomposition:
- Package alu_seq_pkg: state encoding (IDLE=2'b00, ITER=2'b01, DONE=2'b10), OP_ADD=16'hD800, WIDTH default.
- One natural sub-module, alu_src_mux: a combinational select between the ex_* bundle and the sequencer bundle, controlled by state==ITER.

Test Plan:
- Reset, then opA=3, opB=5, start=1 held -> stall high cycles 0-16; done at cycle 17 with product=0x0000000F; stall=0 at cycle 17.
- opA=0xFFFF, opB=0xFFFF -> product=0xFFFE0001 at cycle 17; the carry path is exercised every iteration.
- opA=0, opB=0x1234 -> product=0 at cycle 17; latency unchanged.
- IDLE, start=0, ex_A=5, ex_B=3, ex_Op=0xD800 -> alu_A=5, alu_B=3, alu_Op=0xD800 in the same cycle; stall=0.
- rst=1 at cycle 8 of a multiply -> cycle 9: state IDLE, stall=0, done=0, product=0; done never pulses.
- With MUL_SIGNED_EN: opA=0xFFFD (-3), opB=7, mul_signed=1 -> product=0xFFFFFFEB at cycle 17. Without MUL_SIGNED_EN: same stimulus gives 0x0006FFEB.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the shift-add multiply sequencer: state encoding,
// the ALU opcode it issues while iterating, and the default datapath width.
package alu_seq_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ITER = 2'b01,
    DONE = 2'b10
  } state_t;

  // R-format ADD instruction bits driven onto the ALU during iteration
  localparam logic [15:0] OP_ADD = 16'hD800;

  // Default operand width; must match the ALU datapath
  localparam int DEF_WIDTH = 16;

endpackage

// File: rtl/alu_src_mux.sv
// ALU source select: hands the ALU to the multiply sequencer while it is
// iterating, otherwise passes the execute-stage operands/controls through.
module alu_src_mux #(
  parameter int WIDTH = 16
) (
  input  logic             sel_seq_i,
  // execute-stage bundle
  input  logic [WIDTH-1:0] ex_a_i,
  input  logic [WIDTH-1:0] ex_b_i,
  input  logic [15:0]      ex_op_i,
  input  logic             ex_cin_i,
  input  logic             ex_inv_a_i,
  input  logic             ex_inv_b_i,
  input  logic             ex_sign_i,
  // sequencer bundle
  input  logic [WIDTH-1:0] seq_a_i,
  input  logic [WIDTH-1:0] seq_b_i,
  input  logic [15:0]      seq_op_i,
  input  logic             seq_cin_i,
  input  logic             seq_inv_a_i,
  input  logic             seq_inv_b_i,
  input  logic             seq_sign_i,
  // driven ALU bundle
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  output logic [15:0]      alu_op_o,
  output logic             alu_cin_o,
  output logic             alu_inv_a_o,
  output logic             alu_inv_b_o,
  output logic             alu_sign_o
);

  // Pure combinational select; no state here
  always_comb begin
    if (sel_seq_i) begin
      alu_a_o     = seq_a_i;
      alu_b_o     = seq_b_i;
      alu_op_o    = seq_op_i;
      alu_cin_o   = seq_cin_i;
      alu_inv_a_o = seq_inv_a_i;
      alu_inv_b_o = seq_inv_b_i;
      alu_sign_o  = seq_sign_i;
    end else begin
      alu_a_o     = ex_a_i;
      alu_b_o     = ex_b_i;
      alu_op_o    = ex_op_i;
      alu_cin_o   = ex_cin_i;
      alu_inv_a_o = ex_inv_a_i;
      alu_inv_b_o = ex_inv_b_i;
      alu_sign_o  = ex_sign_i;
    end
  end

endmodule

// File: rtl/alu_mul_seq.sv
// Shift-add multiply sequencer that borrows the EX-stage ALU for WIDTH
// cycles to build a 2*WIDTH product, stalling the pipeline meanwhile.
// Optional signed support is enabled by defining MUL_SIGNED_EN: operands are
// converted to magnitudes on load and the product is negated on output.
module alu_mul_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mul_signed,
  input  logic [WIDTH-1:0]   opA,
  input  logic [WIDTH-1:0]   opB,
  input  logic [WIDTH-1:0]   ex_A,
  input  logic [WIDTH-1:0]   ex_B,
  input  logic [15:0]        ex_Op,
  input  logic               ex_Cin,
  input  logic               ex_invA,
  input  logic               ex_invB,
  input  logic               ex_sign,
  input  logic [WIDTH-1:0]   alu_Out,
  input  logic               alu_Cout,
  output logic [WIDTH-1:0]   alu_A,
  output logic [WIDTH-1:0]   alu_B,
  output logic [15:0]        alu_Op,
  output logic               alu_Cin,
  output logic               alu_invA,
  output logic               alu_invB,
  output logic               alu_sign,
  output logic               stall,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] p_hi_q, p_hi_d;
  logic [WIDTH-1:0] p_lo_q, p_lo_d;
  logic             neg_q, neg_d;

  logic [WIDTH-1:0]   load_m;
  logic [WIDTH-1:0]   load_p_lo;
  logic               load_neg;
  logic [WIDTH-1:0]   seq_b;
  logic [2*WIDTH-1:0] p_full;

`ifdef MUL_SIGNED_EN
  // Local negation to magnitudes; the ALU is not yet ours in IDLE.
  // The most negative value maps to its unsigned magnitude naturally.
  always_comb begin
    load_m    = (mul_signed && opA[WIDTH-1]) ? (~opA + {{(WIDTH-1){1'b0}}, 1'b1}) : opA;
    load_p_lo = (mul_signed && opB[WIDTH-1]) ? (~opB + {{(WIDTH-1){1'b0}}, 1'b1}) : opB;
    load_neg  = mul_signed && (opA[WIDTH-1] ^ opB[WIDTH-1]);
  end
`else
  logic unused_signed;
  assign unused_signed = mul_signed ^ neg_q;

  // Unsigned-only build: operands load as-is and the sign flag stays clear
  always_comb begin
    load_m    = opA;
    load_p_lo = opB;
    load_neg  = 1'b0;
  end
`endif

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      m_q     <= '0;
      p_hi_q  <= '0;
      p_lo_q  <= '0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
      p_hi_q  <= p_hi_d;
      p_lo_q  <= p_lo_d;
      neg_q   <= neg_d;
    end
  end

  // Next-state logic and sequencer outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    m_d     = m_q;
    p_hi_d  = p_hi_q;
    p_lo_d  = p_lo_q;
    neg_d   = neg_q;
    stall   = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        stall = start;
        if (start) begin
          m_d     = load_m;
          p_hi_d  = '0;
          p_lo_d  = load_p_lo;
          neg_d   = load_neg;
          cnt_d   = '0;
          state_d = ITER;
        end
      end
      ITER: begin
        stall = 1'b1;
        // Carry-in to the top of the product, then shift right by one
        {p_hi_d, p_lo_d} = {alu_Cout, alu_Out, p_lo_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // Start is still the retiring instruction's level here; never re-arm
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign seq_b  = p_lo_q[0] ? m_q : '0;
  assign p_full = {p_hi_q, p_lo_q};

`ifdef MUL_SIGNED_EN
  // Restore the sign of the result from the magnitude product
  assign product = neg_q ? (~p_full + {{(2*WIDTH-1){1'b0}}, 1'b1}) : p_full;
`else
  assign product = p_full;
`endif

  alu_src_mux #(
    .WIDTH(WIDTH)
  ) u_src_mux (
    .sel_seq_i   (state_q == ITER),
    .ex_a_i      (ex_A),
    .ex_b_i      (ex_B),
    .ex_op_i     (ex_Op),
    .ex_cin_i    (ex_Cin),
    .ex_inv_a_i  (ex_invA),
    .ex_inv_b_i  (ex_invB),
    .ex_sign_i   (ex_sign),
    .seq_a_i     (p_hi_q),
    .seq_b_i     (seq_b),
    .seq_op_i    (OP_ADD),
    .seq_cin_i   (1'b0),
    .seq_inv_a_i (1'b0),
    .seq_inv_b_i (1'b0),
    .seq_sign_i  (1'b0),
    .alu_a_o     (alu_A),
    .alu_b_o     (alu_B),
    .alu_op_o    (alu_Op),
    .alu_cin_o   (alu_Cin),
    .alu_inv_a_o (alu_invA),
    .alu_inv_b_o (alu_invB),
    .alu_sign_o  (alu_sign)
  );

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed testbench for alu_mul_seq with a behavioural adder standing in
// for the EX-stage ALU. Expected values are hand-computed constants.
module tb_alu_mul_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic        mul_signed;
  logic [15:0] opA, opB;
  logic [15:0] ex_A, ex_B, ex_Op;
  logic        ex_Cin, ex_invA, ex_invB, ex_sign;
  logic [15:0] alu_Out;
  logic        alu_Cout;
  logic [15:0] alu_A, alu_B, alu_Op;
  logic        alu_Cin, alu_invA, alu_invB, alu_sign;
  logic        stall, done;
  logic [31:0] product;

  int errors = 0;
  int checks = 0;

  alu_mul_seq #(.WIDTH(16), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .mul_signed(mul_signed),
    .opA(opA), .opB(opB),
    .ex_A(ex_A), .ex_B(ex_B), .ex_Op(ex_Op),
    .ex_Cin(ex_Cin), .ex_invA(ex_invA), .ex_invB(ex_invB), .ex_sign(ex_sign),
    .alu_Out(alu_Out), .alu_Cout(alu_Cout),
    .alu_A(alu_A), .alu_B(alu_B), .alu_Op(alu_Op),
    .alu_Cin(alu_Cin), .alu_invA(alu_invA), .alu_invB(alu_invB), .alu_sign(alu_sign),
    .stall(stall), .done(done), .product(product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in ALU: adder with optional operand inversion
  always_comb begin
    logic [15:0] a_in, b_in;
    a_in = alu_invA ? ~alu_A : alu_A;
    b_in = alu_invB ? ~alu_B : alu_B;
    {alu_Cout, alu_Out} = {1'b0, a_in} + {1'b0, b_in} + {16'h0, alu_Cin};
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One multiply transaction; start is held through the done cycle.
  task automatic run_mul(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic sgn, input logic [15:0] exp_b1, input logic [31:0] exp_p);
    opA = a; opB = b; mul_signed = sgn; start = 1'b1;
    #1;
    check({name, " stall c0"}, 64'(stall), 64'd1);
    check({name, " done c0"}, 64'(done), 64'd0);
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk); #1;
      check({name, " stall iter"}, 64'(stall), 64'd1);
      check({name, " done iter"}, 64'(done), 64'd0);
      check({name, " alu_Op iter"}, 64'(alu_Op), 64'h0000D800);
      check({name, " alu_Cin iter"}, 64'(alu_Cin), 64'd0);
      if (c == 1) begin
        check({name, " alu_A c1"}, 64'(alu_A), 64'd0);
        check({name, " alu_B c1"}, 64'(alu_B), 64'(exp_b1));
      end
    end
    @(posedge clk); #1;
    check({name, " done c17"}, 64'(done), 64'd1);
    check({name, " stall c17"}, 64'(stall), 64'd0);
    check({name, " product c17"}, 64'(product), 64'(exp_p));
    check({name, " alu_Op passthru c17"}, 64'(alu_Op), 64'(ex_Op));
    start = 1'b0;
    @(posedge clk); #1;
    check({name, " done c18"}, 64'(done), 64'd0);
    check({name, " product held"}, 64'(product), 64'(exp_p));
    $display("mul %s: a=%h b=%h signed=%0b product=%h", name, a, b, sgn, product);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mul_signed = 1'b0;
    opA = '0; opB = '0;
    ex_A = 16'h0; ex_B = 16'h0; ex_Op = 16'h1234;
    ex_Cin = 1'b0; ex_invA = 1'b0; ex_invB = 1'b0; ex_sign = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("reset done", 64'(done), 64'd0);
    check("reset stall", 64'(stall), 64'd0);
    check("reset product", 64'(product), 64'd0);
    $display("reset: done=%0b stall=%0b product=%h", done, stall, product);

    // Passthrough in IDLE
    ex_A = 16'd5; ex_B = 16'd3; ex_Op = 16'hD800;
    ex_Cin = 1'b1; ex_invA = 1'b1; ex_invB = 1'b0; ex_sign = 1'b1;
    #1;
    check("pass alu_A", 64'(alu_A), 64'd5);
    check("pass alu_B", 64'(alu_B), 64'd3);
    check("pass alu_Op", 64'(alu_Op), 64'h0000D800);
    check("pass alu_Cin", 64'(alu_Cin), 64'd1);
    check("pass alu_invA", 64'(alu_invA), 64'd1);
    check("pass alu_invB", 64'(alu_invB), 64'd0);
    check("pass alu_sign", 64'(alu_sign), 64'd1);
    check("pass stall", 64'(stall), 64'd0);
    $display("passthrough: alu_A=%h alu_B=%h alu_Op=%h", alu_A, alu_B, alu_Op);

    // Different ex_Op so passthrough is distinguishable from the ADD issue
    ex_Op = 16'h1234; ex_Cin = 1'b0; ex_invA = 1'b0; ex_sign = 1'b0;
    @(posedge clk); #1;

    run_mul("3x5", 16'd3, 16'd5, 1'b0, 16'd3, 32'h0000000F);
    run_mul("ffff_sq", 16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFF, 32'hFFFE0001);
    run_mul("0x1234", 16'h0000, 16'h1234, 1'b0, 16'h0000, 32'h00000000);
`ifdef MUL_SIGNED_EN
    run_mul("neg3x7", 16'hFFFD, 16'd7, 1'b1, 16'h0003, 32'hFFFFFFEB);
`else
    run_mul("neg3x7", 16'hFFFD, 16'd7, 1'b1, 16'hFFFD, 32'h0006FFEB);
`endif

    // Reset in the middle of a multiply
    opA = 16'd3; opB = 16'd5; mul_signed = 1'b0; start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("midrst stall c9", 64'(stall), 64'd0);
    check("midrst done c9", 64'(done), 64'd0);
    check("midrst product c9", 64'(product), 64'd0);
    check("midrst passthru c9", 64'(alu_Op), 64'h00001234);
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      check("midrst no done", 64'(done), 64'd0);
    end
    $display("midreset: stall=%0b done=%0b product=%h", stall, done, product);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
